// File: rtl/jtag_dtm_pkg.sv
// Shared definitions for the JTAG debug transport module: TAP encodings,
// IR codes, DMI op / status codes and the DTM version.
package jtag_dtm_pkg;

  typedef enum logic [3:0] {
    TAP_EXIT2_DR   = 4'h0,
    TAP_EXIT1_DR   = 4'h1,
    TAP_SHIFT_DR   = 4'h2,
    TAP_PAUSE_DR   = 4'h3,
    TAP_SELECT_IR  = 4'h4,
    TAP_UPDATE_DR  = 4'h5,
    TAP_CAPTURE_DR = 4'h6,
    TAP_SELECT_DR  = 4'h7,
    TAP_EXIT2_IR   = 4'h8,
    TAP_EXIT1_IR   = 4'h9,
    TAP_SHIFT_IR   = 4'hA,
    TAP_PAUSE_IR   = 4'hB,
    TAP_RUN_IDLE   = 4'hC,
    TAP_UPDATE_IR  = 4'hD,
    TAP_CAPTURE_IR = 4'hE,
    TAP_RESET      = 4'hF
  } tap_state_e;

  typedef enum logic [1:0] {DMI_IDLE, DMI_REQ, DMI_WAIT} dmi_state_e;
  typedef enum logic [1:0] {DR_BYPASS, DR_IDCODE, DR_DTMCS, DR_DMI} dr_sel_e;

  localparam logic [4:0] IR_IDCODE = 5'h01;
  localparam logic [4:0] IR_DTMCS  = 5'h10;
  localparam logic [4:0] IR_DMI    = 5'h11;

  localparam logic [1:0] DMI_OP_NOP   = 2'd0;
  localparam logic [1:0] DMI_OP_READ  = 2'd1;
  localparam logic [1:0] DMI_OP_WRITE = 2'd2;

  localparam logic [1:0] DMISTAT_OK     = 2'd0;
  localparam logic [1:0] DMISTAT_FAILED = 2'd2;
  localparam logic [1:0] DMISTAT_BUSY   = 2'd3;

  localparam logic [3:0] DTM_VERSION = 4'h1;

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller; state advances on rising TCK.
// state      | meaning
// RESET      | test-logic-reset, IR forced to IDCODE
// RUN_IDLE   | idle between scans
// SELECT_*   | choose DR or IR column
// CAPTURE_*  | parallel load of shift register
// SHIFT_*    | serial shift TDI -> TDO
// EXIT1/2_*  | leave shift / pause
// PAUSE_*    | hold shift register
// UPDATE_*   | commit shifted value
module jtag_tap_fsm
  import jtag_dtm_pkg::*;
(
  input  logic       tck,
  input  logic       rst,
  input  logic       tms,
  output tap_state_e state
);

  tap_state_e state_q, state_d;

  always_ff @(posedge tck or posedge rst) begin
    if (rst) state_q <= TAP_RESET;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TAP_RESET:      state_d = tms ? TAP_RESET     : TAP_RUN_IDLE;
      TAP_RUN_IDLE:   state_d = tms ? TAP_SELECT_DR : TAP_RUN_IDLE;
      TAP_SELECT_DR:  state_d = tms ? TAP_SELECT_IR : TAP_CAPTURE_DR;
      TAP_CAPTURE_DR: state_d = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
      TAP_SHIFT_DR:   state_d = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
      TAP_EXIT1_DR:   state_d = tms ? TAP_UPDATE_DR : TAP_PAUSE_DR;
      TAP_PAUSE_DR:   state_d = tms ? TAP_EXIT2_DR  : TAP_PAUSE_DR;
      TAP_EXIT2_DR:   state_d = tms ? TAP_UPDATE_DR : TAP_SHIFT_DR;
      TAP_UPDATE_DR:  state_d = tms ? TAP_SELECT_DR : TAP_RUN_IDLE;
      TAP_SELECT_IR:  state_d = tms ? TAP_RESET     : TAP_CAPTURE_IR;
      TAP_CAPTURE_IR: state_d = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
      TAP_SHIFT_IR:   state_d = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
      TAP_EXIT1_IR:   state_d = tms ? TAP_UPDATE_IR : TAP_PAUSE_IR;
      TAP_PAUSE_IR:   state_d = tms ? TAP_EXIT2_IR  : TAP_PAUSE_IR;
      TAP_EXIT2_IR:   state_d = tms ? TAP_UPDATE_IR : TAP_SHIFT_IR;
      TAP_UPDATE_IR:  state_d = tms ? TAP_SELECT_DR : TAP_RUN_IDLE;
      default:        state_d = TAP_RESET;
    endcase
  end

  always_comb state = state_q;

endmodule

// File: rtl/jtag_dtm.sv
// JTAG debug transport module: TAP data registers (IDCODE/DTMCS/DMI/BYPASS)
// and a single-outstanding DMI request engine with response timeout.
// state | meaning
// IDLE  | no transaction outstanding, responses discarded
// REQ   | request presented, waiting for req_ready_i
// WAIT  | request accepted, waiting for response or timeout
module jtag_dtm
  import jtag_dtm_pkg::*;
#(
  parameter int          IR_BITS   = 5,
  parameter int          ABITS     = 7,
  parameter logic [31:0] IDCODE    = 32'h1E200A6F,
  parameter int          IDLE_HINT = 5,
  parameter int          TIMEOUT   = 1023
) (
  input  logic             jtag_TCK,
  input  logic             rst,
  input  logic             jtag_TMS,
  input  logic             jtag_TDI,
  output logic             jtag_TDO,
  output logic             req_valid_o,
  input  logic             req_ready_i,
  output logic [ABITS-1:0] req_addr_o,
  output logic [31:0]      req_data_o,
  output logic [1:0]       req_op_o,
  input  logic             resp_valid_i,
  output logic             resp_ready_o,
  input  logic [31:0]      resp_data_i,
  input  logic [1:0]       resp_op_i,
  output logic             dmi_hardreset_o
);

  localparam int DMI_W  = ABITS + 34;
  localparam int SW     = (DMI_W > IR_BITS) ? DMI_W : IR_BITS;
  localparam int SIDX_W = $clog2(SW);
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  tap_state_e         tap;
  dr_sel_e            dr_sel;
  dmi_state_e         dmi_q, dmi_d;
  logic [IR_BITS-1:0] ir_q;
  logic [SW-1:0]      shift_q, shift_nxt;
  logic [SIDX_W-1:0]  msb_idx;
  logic [1:0]         dmistat_q, dmistat_d, cap_op;
  logic [ABITS-1:0]   last_addr_q, upd_addr;
  logic [31:0]        last_data_q, upd_data, dtmcs_rd;
  logic [1:0]         upd_op;
  logic [CNT_W-1:0]   cnt_q;
  logic               dtmcs_upd, dmi_upd, dmireset, hardreset, issue, resp_take, tmo_hit;

  jtag_tap_fsm u_tap (.tck(jtag_TCK), .rst(rst), .tms(jtag_TMS), .state(tap));

  always_comb begin
    dr_sel = DR_BYPASS;
    if (ir_q == IR_BITS'(IR_IDCODE))     dr_sel = DR_IDCODE;
    else if (ir_q == IR_BITS'(IR_DTMCS)) dr_sel = DR_DTMCS;
    else if (ir_q == IR_BITS'(IR_DMI))   dr_sel = DR_DMI;
  end

  assign dtmcs_rd  = {14'b0, 3'b0, 3'(IDLE_HINT), dmistat_q, 6'(ABITS), DTM_VERSION};
  assign cap_op    = (dmi_q != DMI_IDLE) ? DMISTAT_BUSY : dmistat_q;
  assign upd_op    = shift_q[1:0];
  assign upd_data  = shift_q[33:2];
  assign upd_addr  = shift_q[ABITS+33:34];
  assign dtmcs_upd = (tap == TAP_UPDATE_DR) && (dr_sel == DR_DTMCS);
  assign dmi_upd   = (tap == TAP_UPDATE_DR) && (dr_sel == DR_DMI);
  assign dmireset  = dtmcs_upd && shift_q[16];
  assign hardreset = dtmcs_upd && shift_q[17];
  assign issue     = dmi_upd && (dmistat_q == DMISTAT_OK) && (dmi_q == DMI_IDLE) &&
                     ((upd_op == DMI_OP_READ) || (upd_op == DMI_OP_WRITE));
  assign resp_take = (dmi_q == DMI_WAIT) && resp_valid_i;
  assign tmo_hit   = (dmi_q == DMI_WAIT) && (cnt_q == CNT_W'(TIMEOUT - 1));

  // TDI always enters at the MSB of whichever register is currently selected
  always_comb begin
    msb_idx = '0;
    if (tap == TAP_SHIFT_IR) msb_idx = SIDX_W'(IR_BITS - 1);
    else begin
      case (dr_sel)
        DR_IDCODE, DR_DTMCS: msb_idx = SIDX_W'(31);
        DR_DMI:              msb_idx = SIDX_W'(DMI_W - 1);
        default:             msb_idx = '0;
      endcase
    end
    shift_nxt          = shift_q >> 1;
    shift_nxt[msb_idx] = jtag_TDI;
  end

  always_ff @(posedge jtag_TCK or posedge rst) begin
    if (rst) shift_q <= '0;
    else begin
      case (tap)
        TAP_CAPTURE_IR:             shift_q <= SW'(2'b01);
        TAP_SHIFT_IR, TAP_SHIFT_DR: shift_q <= shift_nxt;
        TAP_CAPTURE_DR: begin
          case (dr_sel)
            DR_IDCODE: shift_q <= SW'(IDCODE | 32'h1);
            DR_DTMCS:  shift_q <= SW'(dtmcs_rd);
            DR_DMI:    shift_q <= SW'({last_addr_q, last_data_q, cap_op});
            default:   shift_q <= '0;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(negedge jtag_TCK or posedge rst) begin
    if (rst) begin
      ir_q     <= IR_BITS'(IR_IDCODE);
      jtag_TDO <= 1'b0;
    end else begin
      if (tap == TAP_RESET)          ir_q <= IR_BITS'(IR_IDCODE);
      else if (tap == TAP_UPDATE_IR) ir_q <= shift_q[IR_BITS-1:0];
      jtag_TDO <= ((tap == TAP_SHIFT_IR) || (tap == TAP_SHIFT_DR)) && shift_q[0];
    end
  end

  always_ff @(posedge jtag_TCK or posedge rst) begin
    if (rst) dmi_q <= DMI_IDLE;
    else     dmi_q <= dmi_d;
  end

  always_comb begin
    dmi_d = dmi_q;
    case (dmi_q)
      DMI_IDLE: if (issue) dmi_d = DMI_REQ;
      DMI_REQ:  if (req_ready_i) dmi_d = DMI_WAIT;
      DMI_WAIT: if (resp_valid_i || tmo_hit) dmi_d = DMI_IDLE;
      default:  dmi_d = DMI_IDLE;
    endcase
    if (hardreset) dmi_d = DMI_IDLE;
  end

  always_comb begin
    req_valid_o  = (dmi_q == DMI_REQ);
    resp_ready_o = (dmi_q != DMI_REQ);
  end

  // Error sticks until dmireset/dmihardreset; a clear in the same cycle wins
  always_comb begin
    dmistat_d = dmistat_q;
    if (dmistat_q == DMISTAT_OK) begin
      if ((tap == TAP_CAPTURE_DR) && (dr_sel == DR_DMI) && (dmi_q != DMI_IDLE))
        dmistat_d = DMISTAT_BUSY;
      else if ((resp_take && resp_op_i[1]) || (tmo_hit && !resp_valid_i))
        dmistat_d = DMISTAT_FAILED;
    end
    if (dmireset || hardreset) dmistat_d = DMISTAT_OK;
  end

  always_ff @(posedge jtag_TCK or posedge rst) begin
    if (rst) begin
      dmistat_q       <= DMISTAT_OK;
      dmi_hardreset_o <= 1'b0;
      req_addr_o      <= '0;
      req_data_o      <= '0;
      req_op_o        <= '0;
      last_addr_q     <= '0;
      last_data_q     <= '0;
      cnt_q           <= '0;
    end else begin
      dmistat_q       <= dmistat_d;
      dmi_hardreset_o <= hardreset;
      if (issue) begin
        req_addr_o  <= upd_addr;
        req_data_o  <= upd_data;
        req_op_o    <= upd_op;
        last_addr_q <= upd_addr;
      end
      if (resp_take) last_data_q <= resp_data_i;
      if (dmi_q == DMI_WAIT) cnt_q <= cnt_q + 1'b1;
      else                   cnt_q <= '0;
    end
  end

endmodule

// File: tb/tb_jtag_dtm.sv
// Directed bench for jtag_dtm: TAP scans drive IDCODE, BYPASS, DTMCS and DMI
// traffic against hand-computed register images.
module tb_jtag_dtm;

  logic        jtag_TCK = 1'b0;
  logic        rst = 1'b0;
  logic        jtag_TMS = 1'b1;
  logic        jtag_TDI = 1'b0;
  logic        jtag_TDO;
  logic        req_valid_o;
  logic        req_ready_i = 1'b0;
  logic [6:0]  req_addr_o;
  logic [31:0] req_data_o;
  logic [1:0]  req_op_o;
  logic        resp_valid_i = 1'b0;
  logic        resp_ready_o;
  logic [31:0] resp_data_i = '0;
  logic [1:0]  resp_op_i = '0;
  logic        dmi_hardreset_o;

  int vectors = 0;
  int miscompares = 0;
  int fire_cnt = 0;
  int hr_cnt = 0;

  logic [4:0]  ir_o;
  logic [63:0] o;
  logic        d;

  jtag_dtm dut (
    .jtag_TCK(jtag_TCK), .rst(rst), .jtag_TMS(jtag_TMS), .jtag_TDI(jtag_TDI),
    .jtag_TDO(jtag_TDO), .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
    .req_addr_o(req_addr_o), .req_data_o(req_data_o), .req_op_o(req_op_o),
    .resp_valid_i(resp_valid_i), .resp_ready_o(resp_ready_o),
    .resp_data_i(resp_data_i), .resp_op_i(resp_op_i),
    .dmi_hardreset_o(dmi_hardreset_o)
  );

  always #5 jtag_TCK = ~jtag_TCK;

  always @(negedge jtag_TCK) begin
    if (req_valid_o && req_ready_i) fire_cnt++;
    if (dmi_hardreset_o) hr_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic tms, input logic tdi, output logic tdo);
    jtag_TMS = tms;
    jtag_TDI = tdi;
    @(negedge jtag_TCK);
    #1 tdo = jtag_TDO;
    @(posedge jtag_TCK);
    #1;
  endtask

  task automatic idle(input int n);
    logic t;
    repeat (n) step(1'b0, 1'b0, t);
  endtask

  task automatic shift_ir(input logic [4:0] din, output logic [4:0] dout);
    logic t;
    step(1'b1, 1'b0, t); step(1'b1, 1'b0, t); step(1'b0, 1'b0, t); step(1'b0, 1'b0, t);
    for (int i = 0; i < 5; i++) begin
      step(i == 4, din[i], t);
      dout[i] = t;
    end
    step(1'b1, 1'b0, t); step(1'b0, 1'b0, t);
  endtask

  task automatic shift_dr(input logic [63:0] din, input int n, output logic [63:0] dout);
    logic t;
    dout = '0;
    step(1'b1, 1'b0, t); step(1'b0, 1'b0, t); step(1'b0, 1'b0, t);
    for (int i = 0; i < n; i++) begin
      step(i == n - 1, din[i], t);
      dout[i] = t;
    end
    step(1'b1, 1'b0, t); step(1'b0, 1'b0, t);
  endtask

  task automatic respond(input logic [31:0] data, input logic [1:0] op);
    logic t;
    resp_valid_i = 1'b1;
    resp_data_i  = data;
    resp_op_i    = op;
    step(1'b0, 1'b0, t);
    resp_valid_i = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    #11;
    check("rst_tdo", jtag_TDO, 0);
    check("rst_req_valid", req_valid_o, 0);
    check("rst_resp_ready", resp_ready_o, 1);
    check("rst_hardreset", dmi_hardreset_o, 0);
    check("rst_req_payload", {req_addr_o, req_data_o, req_op_o}, 0);
    rst = 1'b0;
    @(posedge jtag_TCK);
    #1;
    step(1'b0, 1'b0, d);
    check("tdo_outside_shift", d, 0);

    // IDCODE
    shift_ir(5'h01, ir_o);
    check("ir_capture", ir_o, 5'b00001);
    shift_dr(64'h0, 32, o);
    check("idcode", o[31:0], 32'h1E200A6F);

    // BYPASS
    shift_ir(5'h1F, ir_o);
    shift_dr(64'h3, 2, o);
    check("bypass", o[1:0], 2'b10);

    // DTMCS read
    shift_ir(5'h10, ir_o);
    shift_dr(64'h0, 32, o);
    check("dtmcs_reset", o[31:0], 32'h0000_5071);

    // DMI write, accepted immediately, ok response 3 cycles later
    req_ready_i = 1'b1;
    shift_ir(5'h11, ir_o);
    shift_dr({23'b0, 7'h10, 32'h1, 2'd2}, 41, o);
    check("dmi_cap_reset", o, 64'h0);
    check("wr_req_valid", req_valid_o, 1);
    check("wr_req_payload", {req_addr_o, req_data_o, req_op_o}, {7'h10, 32'h1, 2'd2});
    idle(3);
    respond(32'h1, 2'd0);
    idle(2);
    shift_dr(64'h0, 41, o);
    check("wr_cap", o, {23'b0, 7'h10, 32'h1, 2'd0});
    check("wr_fire_once", fire_cnt, 1);

    // Scan while outstanding: op 3, sticky busy, blocked requests
    req_ready_i = 1'b0;
    shift_dr({23'b0, 7'h22, 32'hA5A5A5A5, 2'd2}, 41, o);
    check("busy_first_cap", o, {23'b0, 7'h10, 32'h1, 2'd0});
    shift_dr({23'b0, 7'h33, 32'h0, 2'd2}, 41, o);
    check("busy_cap", o, {23'b0, 7'h22, 32'h1, 2'd3});
    check("busy_addr_held", req_addr_o, 7'h22);
    check("busy_valid_held", req_valid_o, 1);
    shift_ir(5'h10, ir_o);
    shift_dr(64'h0, 32, o);
    check("dtmcs_busy", o[31:0], 32'h0000_5C71);
    req_ready_i = 1'b1;
    idle(1);
    respond(32'h12345678, 2'd0);
    idle(1);
    check("busy_fire", fire_cnt, 2);
    shift_ir(5'h11, ir_o);
    shift_dr({23'b0, 7'h44, 32'h0, 2'd2}, 41, o);
    check("sticky_cap", o, {23'b0, 7'h22, 32'h12345678, 2'd3});
    check("sticky_blocks", req_valid_o, 0);

    // dmireset, then a read that fails
    shift_ir(5'h10, ir_o);
    shift_dr(64'h10000, 32, o);
    shift_dr(64'h0, 32, o);
    check("dmireset", o[31:0], 32'h0000_5071);
    shift_ir(5'h11, ir_o);
    shift_dr({23'b0, 7'h05, 32'h0, 2'd1}, 41, o);
    check("rd_cap", o, {23'b0, 7'h22, 32'h12345678, 2'd0});
    check("rd_req", {req_valid_o, req_addr_o, req_op_o}, {1'b1, 7'h05, 2'd1});
    idle(1);
    respond(32'hCAFEF00D, 2'd2);
    idle(1);
    shift_ir(5'h10, ir_o);
    shift_dr(64'h0, 32, o);
    check("dtmcs_failed", o[31:0], 32'h0000_5871);

    // Timeout with no response, late response discarded
    shift_dr(64'h10000, 32, o);
    shift_ir(5'h11, ir_o);
    shift_dr({23'b0, 7'h7F, 32'h0, 2'd2}, 41, o);
    idle(1030);
    respond(32'hDEADBEEF, 2'd0);
    idle(1);
    shift_dr(64'h0, 41, o);
    check("timeout_cap", o, {23'b0, 7'h7F, 32'hCAFEF00D, 2'd2});
    check("timeout_fire", fire_cnt, 4);
    shift_ir(5'h10, ir_o);
    shift_dr(64'h0, 32, o);
    check("dtmcs_timeout", o[31:0], 32'h0000_5871);
    shift_dr(64'h10000, 32, o);

    // dmihardreset while the request is stuck in REQ
    req_ready_i = 1'b0;
    shift_ir(5'h11, ir_o);
    shift_dr({23'b0, 7'h11, 32'h0, 2'd1}, 41, o);
    check("hr_req_valid", req_valid_o, 1);
    shift_dr(64'h0, 41, o);
    check("hr_busy_cap", o, {23'b0, 7'h11, 32'hCAFEF00D, 2'd3});
    shift_ir(5'h10, ir_o);
    shift_dr(64'h20000, 32, o);
    check("hr_dtmcs_cap", o[31:0], 32'h0000_5C71);
    check("hr_valid_dropped", req_valid_o, 0);
    check("hr_pulse_high", dmi_hardreset_o, 1);
    idle(2);
    check("hr_pulse_count", hr_cnt, 1);
    shift_dr(64'h0, 32, o);
    check("hr_dmistat", o[31:0], 32'h0000_5071);

    // rst while waiting for a response
    req_ready_i = 1'b1;
    shift_ir(5'h11, ir_o);
    shift_dr({23'b0, 7'h2A, 32'h55, 2'd2}, 41, o);
    idle(2);
    rst = 1'b1;
    #2;
    check("rst2_outputs", {req_valid_o, resp_ready_o, dmi_hardreset_o, jtag_TDO}, 4'b0100);
    check("rst2_payload", {req_addr_o, req_data_o, req_op_o}, 0);
    @(posedge jtag_TCK);
    #1 rst = 1'b0;
    idle(3);
    check("rst2_no_request", {req_valid_o, 32'(fire_cnt)}, {1'b0, 32'd5});
    shift_dr(64'h0, 32, o);
    check("rst2_idcode", o[31:0], 32'h1E200A6F);

    // Five TMS=1 from Shift-DR returns to Test-Logic-Reset
    shift_ir(5'h10, ir_o);
    step(1'b1, 1'b0, d); step(1'b0, 1'b0, d); step(1'b0, 1'b0, d);
    repeat (5) step(1'b1, 1'b0, d);
    step(1'b0, 1'b0, d);
    shift_dr(64'h0, 32, o);
    check("tms_reset_idcode", o[31:0], 32'h1E200A6F);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
